// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC and buffers fetched instructions, with their PC
// and branch prediction, in a small circular FIFO. Decode drains the FIFO with a
// valid/ready handshake, so a decode stall no longer freezes fetch. An execute
// redirect empties the queue and restarts fetch at the corrected PC.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       pred_taken,
    input  logic [31:0]                pred_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_instr,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_pc_plus4,
    output logic                       deq_pred_taken,
    output logic [31:0]                deq_pred_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic          r_mem_pt    [DEPTH];
    logic [31:0]   r_mem_ppc   [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_next_pc;

    // A full queue may still accept a new entry when the head leaves in the same cycle.
    assign deq_valid = (r_count != '0);
    assign w_pop     = deq_valid & deq_ready;
    assign w_push    = (r_count < FULL_CNT) | w_pop;
    assign w_next_pc = pred_taken ? pred_pc : seq_pc(r_fetch_pc);

    assign imem_addr      = r_fetch_pc;
    assign deq_instr      = r_mem_instr[r_rd_ptr];
    assign deq_pc         = r_mem_pc[r_rd_ptr];
    assign deq_pc_plus4   = seq_pc(r_mem_pc[r_rd_ptr]);
    assign deq_pred_taken = r_mem_pt[r_rd_ptr];
    assign deq_pred_pc    = r_mem_ppc[r_rd_ptr];
    assign count          = r_count;

    // Fetch PC, pointers and occupancy; a redirect overrides any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= w_next_pc;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage; cleared on reset so the head fields are never X while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
                r_mem_pt[i]    <= 1'b0;
                r_mem_ppc[i]   <= '0;
            end
        end else if (!redirect_valid && w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_data;
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_pt[r_wr_ptr]    <= pred_taken;
            r_mem_ppc[r_wr_ptr]   <= pred_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: a vector table for the main fetch/drain
// flow plus hand-written sequences for reset, async reset, PC wrap and pointer wrap.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_plus4;
    logic        deq_pred_taken;
    logic [31:0] deq_pred_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // Instruction memory model: instruction word is the inverted address.
    assign imem_data = ~imem_addr;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .deq_pc_plus4   (deq_pc_plus4),
        .deq_pred_taken (deq_pred_taken),
        .deq_pred_pc    (deq_pred_pc),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        pt;
        logic [31:0] ppc;
        logic        rv;
        logic [31:0] rpc;
        logic        e_dv;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ppc;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic pt, input logic [31:0] ppc,
                         input logic rv, input logic [31:0] rpc);
        deq_ready      = rdy;
        pred_taken     = pt;
        pred_pc        = ppc;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] pc);
        chk({nm, "_pc"}, deq_pc, pc);
        chk({nm, "_pc4"}, deq_pc_plus4, pc + 32'd4);
        chk({nm, "_instr"}, deq_instr, ~pc);
    endtask

    initial begin
        int pops;
        int cyc;
        logic [31:0] exp_pc;

        //            rdy pt  ppc          rv  rpc           dv  cnt  addr          pc            pt  ppc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 3'd0, 32'h0,   32'h0,   1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd1, 32'h4,   32'h0,   1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 3'd1, 32'h8,   32'h4,   1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd1, 32'h40,  32'h8,   1'b1, 32'h40};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd1, 32'h44,  32'h40,  1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd2, 32'h48,  32'h40,  1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd3, 32'h4C,  32'h40,  1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd4, 32'h50,  32'h40,  1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd4, 32'h50,  32'h40,  1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd4, 32'h54,  32'h44,  1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h100, 1'b1, 3'd4, 32'h58,  32'h48,  1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 3'd0, 32'h100, 32'h0,   1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 3'd1, 32'h104, 32'h100, 1'b0, 32'h0};

        // Reset values while held in reset.
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", deq_instr, 32'h0);
        chk("rst_pc", deq_pc, 32'h0);
        chk("rst_pc4", deq_pc_plus4, 32'h4);
        chk("rst_pt", 32'(deq_pred_taken), 32'd0);
        chk("rst_ppc", deq_pred_pc, 32'h0);

        // Table: release reset, free-run, prediction, backpressure, redirect while full.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rdy, tbl[i].pt, tbl[i].ppc, tbl[i].rv, tbl[i].rpc);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(deq_valid), 32'(tbl[i].e_dv));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            if (tbl[i].e_dv) begin
                chk_head($sformatf("v%0d", i), tbl[i].e_pc);
                chk($sformatf("v%0d_pt", i), 32'(deq_pred_taken), 32'(tbl[i].e_pt));
                chk($sformatf("v%0d_ppc", i), deq_pred_pc, tbl[i].e_ppc);
            end
            @(negedge clk);
        end

        // Backpressure straight out of reset: fills to 4, fetch stalls at 0x10.
        rst = 1'b0;
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_addr", imem_addr, 32'h10);
        deq_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_pc", k), deq_pc, 32'(k * 4));
            chk($sformatf("bp%0d_count", k), 32'(count), 32'd4);
            @(negedge clk);
        end

        // Async reset mid-stream with three entries held.
        rst = 1'b0;
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("ar_pre_count", 32'(count), 32'd3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_valid", 32'(deq_valid), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);

        // Redirect while empty, then PC wrap at the top of the address space.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("wr_count", 32'(count), 32'd0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("wr_valid", 32'(deq_valid), 32'd1);
        chk_head("wr", 32'hFFFF_FFFC);
        chk("wr_addr2", imem_addr, 32'h0);

        // Pointer wrap: random drain, dequeued PCs must follow fetch order exactly.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'h200;
        pops = 0;
        cyc = 0;
        while (pops < 11 && cyc < 200) begin
            deq_ready = 1'($urandom_range(0, 1));
            #1;
            if (count > 3'd4) begin
                chk("pw_overflow", 32'(count), 32'd4);
            end
            if (deq_valid && deq_ready) begin
                chk($sformatf("pw%0d_pc", pops), deq_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            @(negedge clk);
            cyc++;
        end
        if (pops < 11) begin
            chk("pw_timeout_pops", 32'(pops), 32'd11);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
